// File: rtl/rsa_bus_pkg.sv
// -----------------------------------------------------------------------------
// rsa_bus_pkg
//   Shared definitions for the RSA core operand stream blocks (the modulus
//   serializer, seq_to_para_mod and any later stream blocks).
//
//   Contents:
//     RSA_LEN_DEF / BUS_W_DEF : default modulus and stream word widths
//     MOD_WORDS / PRE_WORDS   : stream words per modulus / per pre-data operand
//     CNT_W                   : width of the stream word counter
//     rsa_bus_state_e         : stream-block state encoding
//     mod_words / pre_words   : word counts for non-default widths
// -----------------------------------------------------------------------------
package rsa_bus_pkg;

  localparam int RSA_LEN_DEF = 512;
  localparam int BUS_W_DEF   = 32;

  localparam int MOD_WORDS = RSA_LEN_DEF / BUS_W_DEF;        // 16
  localparam int PRE_WORDS = RSA_LEN_DEF / (2 * BUS_W_DEF);  // 8

  // The counter has to reach MOD_WORDS + PRE_WORDS (24 by default) and must
  // never wrap, so 5 bits is enough for the default geometry.
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOD  = 2'd1,
    ST_PRE  = 2'd2,
    ST_DONE = 2'd3
  } rsa_bus_state_e;

  // Stream words needed to carry a modulus of rsa_len bits.
  function automatic int mod_words(input int rsa_len, input int bus_w);
    return rsa_len / bus_w;
  endfunction

  // Stream words needed to carry the half-width CRT pre-data operand.
  function automatic int pre_words(input int rsa_len, input int bus_w);
    return rsa_len / (2 * bus_w);
  endfunction

endpackage

// File: rtl/word_shift_acc.sv
// -----------------------------------------------------------------------------
// word_shift_acc
//   Shift-in accumulator for a least-significant-word-first stream. Each
//   enabled cycle the incoming word enters at the top and everything moves
//   down one word, so after WIDTH/WORD_W enables the first word sits in the
//   lowest word slot.
//
//   Ports:
//     clk  : clock
//     rst  : synchronous, active-high reset (register cleared)
//     clr  : synchronous clear (start of a new operand)
//     en   : shift one word in
//     din  : incoming stream word [WORD_W-1:0]
//     q    : accumulated operand [WIDTH-1:0]
// -----------------------------------------------------------------------------
module word_shift_acc #(
  parameter int WIDTH  = 512,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] din,
  output logic [WIDTH-1:0]  q
);

  // Operands are cleared on reset as well as on clr so that an aborted run
  // never leaves a partial operand visible downstream.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[WIDTH-1:WORD_W]};
    end
  end

endmodule

// File: rtl/seq_to_para_mod.sv
// -----------------------------------------------------------------------------
// seq_to_para_mod
//   Receive-side deserializer for the modulus / CRT pre-data word stream on
//   the RSA core operand bus. Sits directly behind the modulus serializer and
//   shares its start strobe and crt qualifier. After start, MOD_WORDS words
//   build the modulus; in CRT mode a further PRE_WORDS words build the
//   pre-data operand. A one-cycle done pulse then hands both operands to the
//   Montgomery core. Outputs hold until the next accepted start.
//
//   Ports:
//     clk        : clock
//     rst        : synchronous, active-high reset
//     start      : one-cycle strobe, same cycle as the serializer's rdy
//     crt        : CRT mode, sampled only in the accepted start cycle
//     data_in    : stream word [BUS_W-1:0]
//     mod_out    : assembled modulus [RSA_LEN-1:0]
//     predat_out : assembled pre-data [RSA_LEN/2-1:0], zero in non-CRT runs
//     busy       : high while capturing words
//     done       : one-cycle pulse when operands are valid
//     err        : modulus odd-check flag
//
//   Build option:
//     SEQ_MOD_ODD_CHK_EN : when defined, err flags an even modulus (bit 0 of
//                          modulus word 0 clear). Held until the next
//                          accepted start or rst. When undefined err is 0.
//
//   Timing (start accepted in cycle 0): busy in cycles 1..16 (1..24 for CRT),
//   done in cycle 17 (25 for CRT).
// -----------------------------------------------------------------------------
module seq_to_para_mod
  import rsa_bus_pkg::*;
#(
  parameter int RSA_LEN = RSA_LEN_DEF,
  parameter int BUS_W   = BUS_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 crt,
  input  logic [BUS_W-1:0]     data_in,
  output logic [RSA_LEN-1:0]   mod_out,
  output logic [RSA_LEN/2-1:0] predat_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // Counter value of the last modulus word and of the last pre-data word.
  // The counter starts at 1 for the first modulus word.
  localparam logic [CNT_W-1:0] LAST_MOD_CNT = CNT_W'(mod_words(RSA_LEN, BUS_W));
  localparam logic [CNT_W-1:0] LAST_PRE_CNT =
    CNT_W'(mod_words(RSA_LEN, BUS_W) + pre_words(RSA_LEN, BUS_W));
  localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(1);

  rsa_bus_state_e   state;
  rsa_bus_state_e   state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             crt_r;
  logic             crt_r_nxt;

  logic             start_acc;  // start seen in IDLE: a run begins
  logic             mod_en;
  logic             pre_en;
  logic             pre_clr;

  // ---------------------------------------------------------------------------
  // Control state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      crt_r <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      crt_r <= crt_r_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath enables
  // ---------------------------------------------------------------------------
  // start is only honoured in IDLE, so strobes during a run or in the done
  // cycle fall through the default assignments and change nothing. crt is
  // consumed only together with an accepted start.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    crt_r_nxt = crt_r;
    start_acc = 1'b0;
    mod_en    = 1'b0;
    pre_en    = 1'b0;
    pre_clr   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          crt_r_nxt = crt;
          cnt_nxt   = FIRST_CNT;
          pre_clr   = 1'b1;
          state_nxt = ST_MOD;
        end
      end

      ST_MOD: begin
        mod_en  = 1'b1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == LAST_MOD_CNT) begin
          state_nxt = crt_r ? ST_PRE : ST_DONE;
        end
      end

      ST_PRE: begin
        pre_en  = 1'b1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == LAST_PRE_CNT) begin
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (state == ST_MOD) || (state == ST_PRE);
  assign done = (state == ST_DONE);

  // ---------------------------------------------------------------------------
  // Operand accumulators
  // ---------------------------------------------------------------------------
  // The modulus is never cleared at start: all of its words are overwritten
  // by every run, so it simply keeps showing the previous operand until then.
  word_shift_acc #(
    .WIDTH  (RSA_LEN),
    .WORD_W (BUS_W)
  ) u_mod_acc (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (mod_en),
    .din (data_in),
    .q   (mod_out)
  );

  // Pre-data is cleared at every accepted start so non-CRT runs present 0.
  word_shift_acc #(
    .WIDTH  (RSA_LEN / 2),
    .WORD_W (BUS_W)
  ) u_pre_acc (
    .clk (clk),
    .rst (rst),
    .clr (pre_clr),
    .en  (pre_en),
    .din (data_in),
    .q   (predat_out)
  );

  // ---------------------------------------------------------------------------
  // Modulus odd check
  // ---------------------------------------------------------------------------
`ifdef SEQ_MOD_ODD_CHK_EN
  logic err_r;

  // Word 0 of the modulus arrives while cnt is still at its first value.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (start_acc) begin
      err_r <= 1'b0;
    end else if (mod_en && (cnt == FIRST_CNT)) begin
      err_r <= ~data_in[0];
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_to_para_mod.sv
// -----------------------------------------------------------------------------
// tb_seq_to_para_mod
//   Self-checking bench for seq_to_para_mod. A stimulus process streams runs
//   (directed and randomized) and, for each completed run, pushes the
//   operands it expects (built by placing stream word i at bit offset
//   32*i) together with the cycle in which done must appear. A monitor pops
//   and compares whenever the DUT raises done.
// -----------------------------------------------------------------------------
module tb_seq_to_para_mod;

  localparam int RSA_LEN = 512;
  localparam int BUS_W   = 32;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 crt;
  logic [BUS_W-1:0]     data_in;
  logic [RSA_LEN-1:0]   mod_out;
  logic [RSA_LEN/2-1:0] predat_out;
  logic                 busy;
  logic                 done;
  logic                 err;

  seq_to_para_mod #(
    .RSA_LEN (RSA_LEN),
    .BUS_W   (BUS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .crt        (crt),
    .data_in    (data_in),
    .mod_out    (mod_out),
    .predat_out (predat_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [511:0] m;
    logic [255:0] p;
    logic         e;
    int           cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc;
  int          n_checks;
  int          n_pass;
  logic [31:0] words[24];
  logic [511:0] last_mod;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 512'(1), 512'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle", 512'(cyc), 512'(e.cyc));
        chk("mod_out", mod_out, e.m);
        chk("predat_out", 512'(predat_out), 512'(e.p));
        chk("err_at_done", 512'(err), 512'(e.e));
        chk("busy_at_done", 512'(busy), 512'(0));
      end
    end
  end

  function automatic logic exp_err_of(input logic [31:0] w0);
`ifdef SEQ_MOD_ODD_CHK_EN
    return ~w0[0];
`else
    return 1'b0;
`endif
  endfunction

  // noise: 0 = no stray starts, 1 = stray starts at cycle 5 and in the done
  // cycle, 2 = random stray starts. rst_at: cycle at which rst is applied
  // instead of a word (0 = never).
  task automatic run(input bit crtv, input int noise, input int rst_at);
    int           n;
    int           c0;
    logic [511:0] em;
    logic [255:0] ep;
    logic         ee;

    n  = crtv ? 24 : 16;
    em = '0;
    ep = '0;
    for (int i = 0; i < 16; i++) em[32*i +: 32] = words[i];
    if (crtv) for (int j = 0; j < 8; j++) ep[32*j +: 32] = words[16+j];
    ee = exp_err_of(words[0]);

    // cycle 0: start accepted
    start   = 1'b1;
    crt     = crtv;
    data_in = $urandom;
    c0      = cyc;
    tick();
    start = 1'b0;

    // cycle 1: pre-data already cleared, modulus still the previous one
    chk("predat_clr_at_start", 512'(predat_out), 512'(0));
    chk("mod_hold_at_start", mod_out, last_mod);

    for (int k = 1; k <= n; k++) begin
      if (k == rst_at) begin
        rst     = 1'b1;
        data_in = $urandom;
        tick();
        rst = 1'b0;
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_mod", mod_out, 512'(0));
        chk("rst_predat", 512'(predat_out), 512'(0));
        chk("rst_err", 512'(err), 512'(0));
        last_mod = '0;
        tick();
        chk("rst_idle_busy", 512'(busy), 512'(0));
        return;
      end
      data_in = words[k-1];
      crt     = 1'($urandom_range(0, 1));
      if (noise == 1)      start = (k == 5);
      else if (noise == 2) start = ($urandom_range(0, 3) == 0);
      else                 start = 1'b0;
      chk("busy_run", 512'(busy), 512'(1));
      chk("err_run", 512'(err), 512'((k >= 2) ? ee : 1'b0));
      tick();
    end

    // cycle n+1: done cycle; a start here must be ignored
    exp_q.push_back('{m: em, p: ep, e: ee, cyc: c0 + n + 1});
    start   = (noise == 1) ? 1'b1 : ((noise == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    data_in = $urandom;
    tick();
    start = 1'b0;

    // cycle n+2: idle, outputs held
    chk("idle_busy", 512'(busy), 512'(0));
    chk("hold_mod", mod_out, em);
    chk("hold_predat", 512'(predat_out), 512'(ep));
    chk("hold_err", 512'(err), 512'(ee));
    last_mod = em;
  endtask

  task automatic fill_directed;
    for (int k = 1; k <= 16; k++) words[k-1] = 32'h1000_0000 + 32'(k);
    for (int j = 0; j < 8; j++)   words[16+j] = 32'hA000_0000 + 32'(j);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_mod = '0;
    rst      = 1'b1;
    start    = 1'b0;
    crt      = 1'b0;
    data_in  = '0;
    repeat (3) tick();
    chk("reset_busy", 512'(busy), 512'(0));
    chk("reset_done", 512'(done), 512'(0));
    chk("reset_mod", mod_out, 512'(0));
    chk("reset_predat", 512'(predat_out), 512'(0));
    chk("reset_err", 512'(err), 512'(0));
    rst = 1'b0;
    tick();
    chk("post_reset_busy", 512'(busy), 512'(0));

    // Directed: non-CRT, CRT, stray starts then immediate restart
    fill_directed();
    run(1'b0, 0, 0);
    tick();
    run(1'b1, 0, 0);
    tick();
    run(1'b0, 1, 0);
    run(1'b0, 0, 0);

    // Reset in the middle of a CRT run, then a fresh run
    run(1'b1, 0, 10);
    run(1'b1, 0, 0);

    // CRT followed directly by non-CRT: pre-data must return to zero
    for (int i = 0; i < 24; i++) words[i] = $urandom;
    run(1'b0, 0, 0);
    tick();

    // Even then odd first modulus word
    words[0] = 32'h0000_0002;
    run(1'b0, 0, 0);
    words[0] = 32'h0000_0003;
    run(1'b0, 0, 0);
    tick();

    // Randomized runs with random gaps, stray starts and crt toggling
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 24; i++) words[i] = $urandom;
      run(1'($urandom_range(0, 1)), 2, 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (4) tick();
    chk("queue_empty", 512'(exp_q.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
